// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU execution sequencer:
// FSM states, ALU op codes, PSR bit positions and the PSR load-mask rule.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;

  localparam int PSR_C    = 0;
  localparam int PSR_L    = 1;
  localparam int PSR_F    = 2;
  localparam int PSR_Z    = 3;
  localparam int PSR_N    = 4;
  localparam int PSR_BITS = 5;

  localparam int OP_CMP_BIT = 3;

  // Logical ops only refresh Z and N; arithmetic ops and compares load every flag.
  function automatic logic [PSR_BITS-1:0] psr_load_mask(input logic [3:0] op);
    logic [PSR_BITS-1:0] mask;
    mask = '1;
    if (!op[OP_CMP_BIT] && (op[1:0] inside {ALU_AND[1:0], ALU_OR[1:0], ALU_XOR[1:0]})) begin
      mask        = '0;
      mask[PSR_Z] = 1'b1;
      mask[PSR_N] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_psr_reg.sv
// Processor status register: each bit loads its flag input when its mask bit
// is set and otherwise holds.
module psr_reg
  import alu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PSR_BITS-1:0] load_mask,
  input  logic [PSR_BITS-1:0] flags_in,
  output logic [PSR_BITS-1:0] psr
);

  logic [PSR_BITS-1:0] psr_q, psr_d;

  always_comb begin
    psr_d = (psr_q & ~load_mask) | (flags_in & load_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psr_q <= '0;
    end else begin
      psr_q <= psr_d;
    end
  end

  assign psr = psr_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-state sequencer (IDLE, READ, EXEC, WRITE) running one ALU instruction at
// a time: operand read, external ALU evaluation, writeback and PSR update.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_op,
  input  logic               instr_imm_en,
  input  logic [REGBITS-1:0] instr_rdest,
  input  logic [REGBITS-1:0] instr_rsrc,
  input  logic [7:0]         instr_imm,
  output logic [REGBITS-1:0] rf_raddr_a,
  output logic [REGBITS-1:0] rf_raddr_b,
  input  logic [WIDTH-1:0]   rf_rdata_a,
  input  logic [WIDTH-1:0]   rf_rdata_b,
  output logic               rf_we,
  output logic [REGBITS-1:0] rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic [WIDTH-1:0]   alu_dst,
  output logic [WIDTH-1:0]   alu_src,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_c,
  input  logic               alu_l,
  input  logic               alu_f,
  input  logic               alu_z,
  input  logic               alu_n,
  output logic [4:0]         psr,
  output logic               done,
  output state_e             dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE, and
  // instr_valid is ignored in every other state (no queuing).

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic                 imm_en_q, imm_en_d;
  logic [REGBITS-1:0]   rdest_q, rdest_d;
  logic [REGBITS-1:0]   rsrc_q, rsrc_d;
  logic [7:0]           imm_q, imm_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [PSR_BITS-1:0]  flags_q, flags_d;
  logic [PSR_BITS-1:0]  psr_mask;
  logic                 is_cmp;

  assign is_cmp = op_q[OP_CMP_BIT];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_en_d = imm_en_q;
    rdest_d  = rdest_q;
    rsrc_d   = rsrc_q;
    imm_d    = imm_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d     = instr_op;
          imm_en_d = instr_imm_en;
          rdest_d  = instr_rdest;
          rsrc_d   = instr_rsrc;
          imm_d    = instr_imm;
          state_d  = ST_READ;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        result_d       = alu_result;
        flags_d[PSR_C] = alu_c;
        flags_d[PSR_L] = alu_l;
        flags_d[PSR_F] = alu_f;
        flags_d[PSR_Z] = alu_z;
        flags_d[PSR_N] = alu_n;
        state_d        = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      imm_en_q <= 1'b0;
      rdest_q  <= '0;
      rsrc_q   <= '0;
      imm_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_en_q <= imm_en_d;
      rdest_q  <= rdest_d;
      rsrc_q   <= rsrc_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Every external strobe is a decode of the state register, zero outside its state.
  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_dst     = '0;
    alu_src     = '0;
    alu_op      = ALU_ADD;
    done        = 1'b0;
    psr_mask    = '0;
    case (state_q)
      ST_READ: begin
        rf_raddr_a = rdest_q;
        rf_raddr_b = rsrc_q;
      end
      ST_EXEC: begin
        alu_dst = rf_rdata_a;
        alu_src = imm_en_q ? {{(WIDTH-8){imm_q[7]}}, imm_q} : rf_rdata_b;
        alu_op  = is_cmp ? ALU_SUB : op_q[2:0];
      end
      ST_WRITE: begin
        done     = 1'b1;
        psr_mask = psr_load_mask(op_q);
        if (!is_cmp) begin
          rf_we    = 1'b1;
          rf_waddr = rdest_q;
          rf_wdata = result_q;
        end
      end
      default: ;
    endcase
  end

  psr_reg u_psr (
    .clk       (clk),
    .rst       (reset),
    .load_mask (psr_mask),
    .flags_in  (flags_q),
    .psr       (psr)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU and register file around the DUT,
// directed cases followed by random instructions checked against a reference model.
module tb_alu_exec_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready, instr_imm_en;
  logic [3:0]  instr_op, instr_rdest, instr_rsrc;
  logic [7:0]  instr_imm;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_dst, alu_src, alu_result;
  logic [2:0]  alu_op;
  logic        alu_c, alu_l, alu_f, alu_z, alu_n;
  logic [4:0]  psr;
  logic        done;
  state_e      dbg_state;

  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] regs [16];
  logic [15:0] ref_regs [16];
  logic [4:0]  ref_psr;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          write_cnt = 0;
  int          done_cnt = 0;
  int          acc_q[$];

  always #5 clk = ~clk;

  alu_exec_ctrl #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_imm_en(instr_imm_en), .instr_rdest(instr_rdest), .instr_rsrc(instr_rsrc),
    .instr_imm(instr_imm),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_dst(alu_dst), .alu_src(alu_src), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_l(alu_l), .alu_f(alu_f),
    .alu_z(alu_z), .alu_n(alu_n),
    .psr(psr), .done(done), .dbg_state(dbg_state)
  );

  // Team ALU: Z from the result, L/N are unsigned/signed src>dst, C carry or borrow, F overflow.
  function automatic logic [20:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic c, f, l, n, z;
    s = '0; r = '0; c = 1'b0; f = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b100: begin
        r = a - b;
        c = (a < b);
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b001:  r = a & b;
      3'b010:  r = a | b;
      3'b011:  r = a ^ b;
      default: r = '0;
    endcase
    l = (b > a);
    n = ($signed(b) > $signed(a));
    z = (r == 16'h0000);
    return {n, z, f, l, c, r};
  endfunction

  always_comb begin
    {alu_n, alu_z, alu_f, alu_l, alu_c, alu_result} = alu_fn(alu_op, alu_dst, alu_src);
  end

  // Synchronous-read register file with a bench preload port, plus event monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (pl_we) regs[pl_addr] <= pl_data;
    if (rf_we) write_cnt <= write_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (instr_valid && instr_ready && !reset) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_regs[a] = d;
  endtask

  // Reference: one instruction applied to the mirrored register file and PSR.
  task automatic ref_apply(input logic [3:0] op, input logic ie, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [7:0] imm,
                           output logic [15:0] a, output logic [15:0] b,
                           output logic [15:0] res, output logic [2:0] aop);
    logic [20:0] r;
    a   = ref_regs[rd];
    b   = ie ? {{8{imm[7]}}, imm} : ref_regs[rs];
    aop = op[3] ? 3'b100 : op[2:0];
    r   = alu_fn(aop, a, b);
    res = r[15:0];
    if (op[3] || op[1:0] == 2'b00) ref_psr = r[20:16];
    else ref_psr = {r[20:19], ref_psr[2:0]};
    if (!op[3]) ref_regs[rd] = res;
  endtask

  task automatic drive(input logic [3:0] op, input logic ie, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [7:0] imm);
    instr_valid = 1'b1; instr_op = op; instr_imm_en = ie;
    instr_rdest = rd; instr_rsrc = rs; instr_imm = imm;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ie, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [7:0] imm);
    logic [15:0] a, b, res;
    logic [2:0]  aop;
    logic [4:0]  old_psr;
    int          wc0, dc0;
    old_psr = ref_psr;
    ref_apply(op, ie, rd, rs, imm, a, b, res, aop);
    chk("ready_idle", 32'(instr_ready), 32'd1);
    wc0 = write_cnt; dc0 = done_cnt;
    drive(op, ie, rd, rs, imm);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("read_ready", 32'(instr_ready), 32'd0);
    chk("read_addr_a", 32'(rf_raddr_a), 32'(rd));
    chk("read_addr_b", 32'(rf_raddr_b), 32'(rs));
    chk("read_alu_dst", 32'(alu_dst), 32'd0);
    @(posedge clk); #1;
    chk("exec_alu_dst", 32'(alu_dst), 32'(a));
    chk("exec_alu_src", 32'(alu_src), 32'(b));
    chk("exec_alu_op", 32'(alu_op), 32'(aop));
    chk("exec_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    chk("write_done", 32'(done), 32'd1);
    chk("write_we", 32'(rf_we), 32'(!op[3]));
    if (!op[3]) begin
      chk("write_waddr", 32'(rf_waddr), 32'(rd));
      chk("write_wdata", 32'(rf_wdata), 32'(res));
    end
    chk("write_psr_old", 32'(psr), 32'(old_psr));
    @(posedge clk); #1;
    chk("post_psr", 32'(psr), 32'(ref_psr));
    chk("post_ready", 32'(instr_ready), 32'd1);
    chk("post_done", 32'(done), 32'd0);
    chk("post_writes", 32'(write_cnt - wc0), 32'(!op[3]));
    chk("post_done_cnt", 32'(done_cnt - dc0), 32'd1);
    chk("post_reg", 32'(regs[rd]), 32'(ref_regs[rd]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, res;
    logic [2:0]  aop;
    logic [2:0]  op_tab [5];
    logic [15:0] corner [4];
    int          wc0, dc0, acc0;
    logic [3:0]  rop, rd, rs;
    op_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    reset = 1'b1;
    instr_valid = 1'b0; instr_op = '0; instr_imm_en = 1'b0;
    instr_rdest = '0; instr_rsrc = '0; instr_imm = '0;
    ref_psr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_psr", 32'(psr), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'({rf_raddr_a, rf_raddr_b, rf_waddr}), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_alu", 32'({alu_dst, alu_src}), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom_range(0, 65535)));

    // ADD overflow: 0x7FFF + 1
    set_reg(4'd1, 16'h7FFF); set_reg(4'd2, 16'h0001);
    run_instr(4'b0000, 1'b0, 4'd1, 4'd2, 8'h00);
    chk("add_r1", 32'(regs[1]), 32'h8000);
    chk("add_psr", 32'(psr), 32'b00100);

    // AND keeps C/L/F, loads Z and N
    set_reg(4'd1, 16'h00F0); set_reg(4'd2, 16'h0F00);
    run_instr(4'b0001, 1'b0, 4'd1, 4'd2, 8'h00);
    chk("and_r1", 32'(regs[1]), 32'h0000);
    chk("and_psr", 32'(psr), 32'b11100);

    // Compare of equal values: no writeback
    set_reg(4'd3, 16'h0005); set_reg(4'd4, 16'h0005);
    run_instr(4'b1000, 1'b0, 4'd3, 4'd4, 8'h00);
    chk("cmp_psr", 32'(psr), 32'b01000);
    chk("cmp_r3", 32'(regs[3]), 32'h0005);

    // ADD immediate with sign-extended 0xFF
    set_reg(4'd5, 16'h0001);
    run_instr(4'b0000, 1'b1, 4'd5, 4'd0, 8'hFF);
    chk("addi_r5", 32'(regs[5]), 32'h0000);
    chk("addi_psr", 32'(psr), 32'b01011);

    // Same register as both operands
    set_reg(4'd9, 16'h4321);
    run_instr(4'b0011, 1'b0, 4'd9, 4'd9, 8'h00);
    chk("xor_self", 32'(regs[9]), 32'h0000);

    // Reset during EXEC aborts the instruction
    set_reg(4'd8, 16'h1234); set_reg(4'd9, 16'h0001);
    wc0 = write_cnt; dc0 = done_cnt;
    drive(4'b0000, 1'b0, 4'd8, 4'd9, 8'h00);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_exec", 32'(dbg_state), 32'(ST_EXEC));
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_psr", 32'(psr), 32'd0);
    chk("abort_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    chk("abort_ready_held", 32'(instr_ready), 32'd1);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_write", 32'(write_cnt - wc0), 32'd0);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("abort_r8", 32'(regs[8]), 32'h1234);
    chk("abort_psr_after", 32'(psr), 32'd0);
    chk("abort_ready_after", 32'(instr_ready), 32'd1);
    ref_psr = '0;

    // Held instr_valid: back-to-back acceptance every 4 cycles
    set_reg(4'd6, 16'h0100); set_reg(4'd7, 16'h0011);
    wc0 = write_cnt; dc0 = done_cnt; acc0 = acc_q.size();
    ref_apply(4'b0000, 1'b0, 4'd6, 4'd7, 8'h00, a, b, res, aop);
    ref_apply(4'b0000, 1'b0, 4'd6, 4'd7, 8'h00, a, b, res, aop);
    drive(4'b0000, 1'b0, 4'd6, 4'd7, 8'h00);
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("b2b_ready_low_c%0d", k), 32'(instr_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("b2b_ready_c4", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_q.size() - acc0), 32'd2);
    if (acc_q.size() >= acc0 + 2)
      chk("b2b_spacing", 32'(acc_q[acc0+1] - acc_q[acc0]), 32'd4);
    chk("b2b_second_read", 32'(dbg_state), 32'(ST_READ));
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_r6", 32'(regs[6]), 32'(ref_regs[6]));
    chk("b2b_psr", 32'(psr), 32'(ref_psr));
    chk("b2b_writes", 32'(write_cnt - wc0), 32'd2);
    chk("b2b_dones", 32'(done_cnt - dc0), 32'd2);

    // Random instruction mix
    for (int i = 0; i < 30; i++) begin
      rop = {($urandom_range(0, 3) == 0), op_tab[$urandom_range(0, 4)]};
      rd  = 4'($urandom_range(0, 15));
      rs  = 4'($urandom_range(0, 15));
      if (i % 4 == 0) set_reg(rs, corner[$urandom_range(0, 3)]);
      run_instr(rop, 1'($urandom_range(0, 1)), rd, rs, 8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
